// File: rtl/display_driver.sv
// Purpose : time-multiplexed 4-digit 7-segment driver for a mm.ss stopwatch, with per-mode digit blinking.
// Latency : seg/an/dp are registered; a new digit index reaches the pins one clk after the index changes.
// Backpres: none; mins/secs/state are sampled once per frame and never stalled.
//
// Ports:
//   clk            system clock, all state on rising edge
//   rst            asynchronous active-high reset
//   state[1:0]     00 run, 01 adjust mins, 10 adjust secs, 11 paused
//   mins[5:0]      minutes value from the counter stage
//   secs[5:0]      seconds value from the counter stage
//   seg[6:0]       active-low cathodes, seg[6]=a .. seg[0]=g
//   an[3:0]        active-low anodes: [3] min tens, [2] min ones, [1] sec tens, [0] sec ones
//   dp             active-low decimal point, lit on min ones as the mm.ss separator
//
// Build option: define LEADING_ZERO_BLANK_EN to blank a zero minute-tens digit.

module display_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] state,
    input  logic [5:0] mins,
    input  logic [5:0] secs,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp
);

    localparam int TW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b1111110;

    logic [TW-1:0] tick;
    logic [1:0]    idx;
    logic [5:0]    snap_mins;
    logic [5:0]    snap_secs;
    logic [1:0]    snap_state;
    logic [BW-1:0] bcnt;
    logic          phase;

    logic          tick_tc;
    logic [5:0]    val;
    logic [3:0]    digit;
    logic          is_dash;
    logic          blank;
    logic [6:0]    seg_nxt;

    function automatic logic [6:0] enc7(input logic [3:0] d);
        case (d)
            4'd0:    enc7 = 7'b0000001;
            4'd1:    enc7 = 7'b1001111;
            4'd2:    enc7 = 7'b0010010;
            4'd3:    enc7 = 7'b0000110;
            4'd4:    enc7 = 7'b1001100;
            4'd5:    enc7 = 7'b0100100;
            4'd6:    enc7 = 7'b0100000;
            4'd7:    enc7 = 7'b0001111;
            4'd8:    enc7 = 7'b0000000;
            4'd9:    enc7 = 7'b0000100;
            default: enc7 = SEG_BLANK;
        endcase
    endfunction

    assign tick_tc = (tick == TW'(REFRESH_DIV - 1));

    // Scan timing and frame snapshot. The snapshot is taken as the last digit
    // of a frame ends, so all four digits of the next frame come from one value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick       <= '0;
            idx        <= '0;
            snap_mins  <= '0;
            snap_secs  <= '0;
            snap_state <= '0;
        end else begin
            if (tick_tc) begin
                tick <= '0;
                idx  <= idx + 2'd1;
                if (idx == 2'd3) begin
                    snap_mins  <= mins;
                    snap_secs  <= secs;
                    snap_state <= state;
                end
            end else begin
                tick <= tick + TW'(1);
            end
        end
    end

    // Blink phase. A pending mode change (input state not yet in the snapshot)
    // holds the phase visible, so the new mode starts from a full visible half-period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcnt  <= '0;
            phase <= 1'b1;
        end else if (state != snap_state) begin
            bcnt  <= '0;
            phase <= 1'b1;
        end else if (bcnt == BW'(BLINK_DIV - 1)) begin
            bcnt  <= '0;
            phase <= ~phase;
        end else begin
            bcnt <= bcnt + BW'(1);
        end
    end

    // Digit selection: idx[1] picks minutes vs seconds, idx[0] picks tens vs ones.
    always_comb begin
        val     = idx[1] ? snap_mins : snap_secs;
        is_dash = (val >= 6'd60);
        digit   = idx[0] ? 4'(val / 6'd10) : 4'(val % 6'd10);

        blank = 1'b0;
        if (!phase) begin
            case (snap_state)
                2'b01:   blank = idx[1];
                2'b10:   blank = ~idx[1];
                2'b11:   blank = 1'b1;
                default: blank = 1'b0;
            endcase
        end
`ifdef LEADING_ZERO_BLANK_EN
        // Out-of-range minutes still show dashes rather than a blank.
        if ((idx == 2'd3) && !is_dash && (val < 6'd10)) begin
            blank = 1'b1;
        end
`endif

        if (blank) begin
            seg_nxt = SEG_BLANK;
        end else if (is_dash) begin
            seg_nxt = SEG_DASH;
        end else begin
            seg_nxt = enc7(digit);
        end
    end

    // Anode stays asserted for blanked digits so scan timing never changes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg <= SEG_BLANK;
            an  <= 4'b1111;
            dp  <= 1'b1;
        end else begin
            seg <= seg_nxt;
            an  <= ~(4'b0001 << idx);
            dp  <= (idx != 2'd2);
        end
    end

endmodule

// File: tb/tb_display_driver.sv
module tb_display_driver;

    localparam int R = 4;
    localparam int B = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] state = 2'd0;
    logic [5:0] mins = 6'd0;
    logic [5:0] secs = 6'd0;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;

    display_driver #(.REFRESH_DIV(R), .BLINK_DIV(B)) dut (
        .clk   (clk),
        .rst   (rst),
        .state (state),
        .mins  (mins),
        .secs  (secs),
        .seg   (seg),
        .an    (an),
        .dp    (dp)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [6:0] enc [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                             7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

    // Reference model: e = edges since reset release, f = edge of the most recent
    // mode-change restart (0 = reset). Scan position and blink phase follow from
    // plain division on those counts; snapshots are the inputs seen at each
    // frame-ending edge (every 4*R edges).
    int         e = 0;
    int         f = 0;
    int         xph = 1;
    logic [5:0] sm = 6'd0;
    logic [5:0] ss = 6'd0;
    logic [1:0] sst = 2'd0;
    logic [6:0] xseg = 7'h7F;
    logic [3:0] xan = 4'hF;
    logic       xdp = 1'b1;
    bit         chk_en = 1'b0;

    always @(posedge clk) begin
        int idx, v, d;
        bit blank, dash;
        if (rst) begin
            e = 0; f = 0; xph = 1;
            sm = 6'd0; ss = 6'd0; sst = 2'd0;
            xseg = 7'h7F; xan = 4'hF; xdp = 1'b1;
        end else begin
            e++;
            idx  = ((e - 1) / R) % 4;
            xph  = 1 - (((e - 1 - f) / B) % 2);
            v    = (idx >= 2) ? int'(sm) : int'(ss);
            dash = (v >= 60);
            d    = (idx % 2 == 1) ? v / 10 : v % 10;
            blank = 1'b0;
            if (xph == 0) begin
                case (sst)
                    2'd1:    blank = (idx >= 2);
                    2'd2:    blank = (idx < 2);
                    2'd3:    blank = 1'b1;
                    default: blank = 1'b0;
                endcase
            end
`ifdef LEADING_ZERO_BLANK_EN
            if (idx == 3 && !dash && v < 10) blank = 1'b1;
`endif
            xseg = blank ? 7'h7F : (dash ? 7'b1111110 : enc[d]);
            xan  = 4'hF;
            xan[idx] = 1'b0;
            xdp  = (idx != 2);
            if (state != sst) f = e;
            if (e % (4 * R) == 0) begin
                sm = mins; ss = secs; sst = state;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_seg", 32'(seg), 32'(xseg));
            check("cyc_an",  32'(an),  32'(xan));
            check("cyc_dp",  32'(dp),  32'(xdp));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_an",  32'(an),  32'h0000000F);
        check("rst_mid_seg", 32'(seg), 32'h0000007F);
        check("rst_mid_dp",  32'(dp),  32'h00000001);
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int guard;
        mins = 6'd12; secs = 6'd34; state = 2'd0;
        repeat (3) @(negedge clk);
        check("reset_an",  32'(an),  32'h0000000F);
        check("reset_seg", 32'(seg), 32'h0000007F);
        check("reset_dp",  32'(dp),  32'h00000001);
        chk_en = 1'b1;
        rst = 1'b0;

        // First frame shows the reset snapshot, second frame shows 12:34.
        step(17);
        check("scan0_an",  32'(an),  32'h0000000E);
        check("scan0_seg", 32'(seg), 32'(7'b1001100));
        check("scan0_dp",  32'(dp),  32'h00000001);
        mins = 6'd13;
        step(4);
        check("scan1_an",  32'(an),  32'h0000000D);
        check("scan1_seg", 32'(seg), 32'(7'b0000110));
        step(4);
        check("hold12_an",  32'(an),  32'h0000000B);
        check("hold12_seg", 32'(seg), 32'(7'b0010010));
        check("hold12_dp",  32'(dp),  32'h00000000);
        step(4);
        check("scan3_an",  32'(an),  32'h00000007);
        check("scan3_seg", 32'(seg), 32'(7'b1001111));
        step(12);
        check("new13_an",  32'(an),  32'h0000000B);
        check("new13_seg", 32'(seg), 32'(7'b0000110));

        // Adjust-minutes blinking.
        state = 2'd1; mins = 6'd5; secs = 6'd7;
        repeat (160) @(negedge clk);

        // Out-of-range seconds show dashes.
        state = 2'd0; secs = 6'd62; mins = 6'd63;
        repeat (64) @(negedge clk);

        // Switch to paused while the blink phase is 0.
        guard = 0;
        while (xph != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("phase0_seen", 32'(xph == 0), 32'd1);
        state = 2'd3;
        repeat (120) @(negedge clk);

        // Mid-frame reset with a single-digit minute value.
        state = 2'd0; mins = 6'd3; secs = 6'd9;
        repeat (6) @(negedge clk);
        pulse_reset();
        step(1);
        check("restart_an",  32'(an),  32'h0000000E);
        check("restart_seg", 32'(seg), 32'(7'b0000001));
        repeat (60) @(negedge clk);

        // Randomized values, modes and occasional resets.
        repeat (250) begin
            mins = 6'($urandom_range(0, 63));
            secs = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 3) == 0) state = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 39) == 0) pulse_reset();
            repeat ($urandom_range(1, 30)) @(negedge clk);
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/display_driver.md
DISPLAY_DRIVER -- requirements
Module: display_driver

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, clk cycles each digit is driven (minimum 2).
REQ-002 SHALL have parameter BLINK_DIV, default 25000000, clk cycles per blink half-period (minimum 2).
REQ-003 SHALL have port clk  input  1  single system clock; all state is on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port state  input  2  stopwatch mode: 00 run, 01 adjust mins, 10 adjust secs, 11 paused.
REQ-006 SHALL have port mins  input  6  minutes value from the counter stage.
REQ-007 SHALL have port secs  input  6  seconds value from the counter stage.
REQ-008 SHALL have port seg  output  7  segment cathodes, active-low, seg[6]=a through seg[0]=g.
REQ-009 SHALL have port an  output  4  digit anodes, active-low: an[3]=min tens, an[2]=min ones, an[1]=sec tens, an[0]=sec ones.
REQ-010 SHALL have port dp  output  1  decimal point, active-low.

Function
REQ-011 SHALL use a tick counter counting 0..REFRESH_DIV-1; at terminal count it wraps to 0 and advances the digit index 0->1->2->3->0.
REQ-012 SHALL capture mins, secs and state into snapshot registers on the cycle the tick counter is at terminal count and the digit index is 3 (frame boundary); a frame always shows one coherent value.
REQ-013 SHALL split each snapshot value into tens = v/10 and ones = v%10.
REQ-014 SHALL display a snapshot value of 60..63 as two dash digits (g only lit, seg=1111110).
REQ-015 SHALL use encodings 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100; a blank digit is seg=1111111.
REQ-016 SHALL register seg, an and dp; outputs reflect a new digit index one clk cycle after the index changes.
REQ-017 SHALL drive exactly one an bit low at any time after the first post-reset update.
REQ-018 SHALL drive dp low only while the min ones digit (index 2) is active, as the mm.ss separator; dp is not blinked.
REQ-019 SHALL keep a blink phase bit toggling every BLINK_DIV cycles; phase 1 = visible.
REQ-020 SHALL blank the digits, based on snapshot state, during phase 0: 01 -> both minute digits, 10 -> both second digits, 11 -> all four digits, 00 -> none.
REQ-021 SHALL clear the blink counter and force phase 1 on any cycle where the input state differs from the snapshot state, so a mode change is immediately visible.
REQ-022 SHALL keep an asserted for blanked digits (seg=1111111) so that scan timing is unchanged.

Reset
REQ-023 SHALL, on rst high and asynchronously: tick counter 0, digit index 0, mins/secs snapshot 0, state snapshot 00, blink counter 0, phase 1, seg=1111111, an=1111, dp=1.
REQ-024 SHALL hold all outputs at their reset values while rst is high and resume scanning from digit 0 on the first edge after release.
REQ-025 SHALL, when rst asserts mid-frame, discard the frame; no partial value appears after release.

Configuration
REQ-026 SHALL honour macro LEADING_ZERO_BLANK_EN: when defined, the min tens digit is blanked (seg=1111111) when its value is 0; when undefined, it shows 0.
REQ-027 SHALL, with LEADING_ZERO_BLANK_EN defined, still show dashes for minute values 60..63.

Verification
REQ-028 SHALL cover the following scenario (REFRESH_DIV=4, BLINK_DIV=16): mins=12, secs=34, state=00 -> after the first frame, an cycles 1110,1101,1011,0111 every 4 clks with seg 4,3,2,1 and dp low only with an=1011.
REQ-029 SHALL cover the following scenario: mins changes 12->13 mid-frame -> displayed minutes stay 12 until the next frame boundary, then show 13.
REQ-030 SHALL cover the following scenario: state=01, mins=5, secs=7 -> minute digits alternate between 0,5 and blank every 16 clks; second digits are steady 0,7.
REQ-031 SHALL cover the following scenario: secs=62 -> second digits both show 1111110.
REQ-032 SHALL cover the following scenario: state 00->11 while phase is 0 -> phase forced to 1 on the next edge; all digits blank after 16 more clks.
REQ-033 SHALL cover the following scenario: rst pulsed mid-frame -> an=1111 and seg=1111111 immediately; scanning restarts at an=1110; with LEADING_ZERO_BLANK_EN and mins=3, the min tens digit is blank.
